// File: rtl/instruction_assembler_if.sv
// Field-tuple input handshake and instruction-memory write port of instruction_assembler.
// The master modport is the side that supplies tuples and owns the memory; the slave is the assembler.
interface instruction_assembler_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        func3;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [6:0]        func7;
  logic [31:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    output in_valid, opcode, rd, func3, rs1, rs2, func7, imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, opcode, rd, func3, rs1, rs2, func7, imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instruction_assembler.sv
// Packs RV32I fields into machine words and streams them through a FIFO into instruction memory.
// Define ILLEGAL_OPCODE_CHECK_EN to drop tuples with unlisted opcodes and report them on err/err_count.
module instruction_assembler #(
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  instruction_assembler_if.slave bus,
  output logic [ADDR_W:0]     count,
  output logic                busy,
  output logic                err,
  output logic [7:0]          err_count
);
  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    DEPTH_L   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE_L    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0]       word;
  logic              illegal;
  logic              accept;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    occ;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              unused_imm;

  // Branch and jump offsets are halfword-aligned, so imm[0] never reaches the word.
  assign unused_imm = bus.imm[0];

  always_comb begin
    word    = {bus.func7, bus.rs2, bus.rs1, bus.func3, bus.rd, bus.opcode};
    illegal = 1'b0;
    case (bus.opcode)
      OP_R: word = {bus.func7, bus.rs2, bus.rs1, bus.func3, bus.rd, bus.opcode};
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
        word = {bus.imm[11:0], bus.rs1, bus.func3, bus.rd, bus.opcode};
      OP_STORE:
        word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.func3, bus.imm[4:0], bus.opcode};
      OP_BRANCH:
        word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.func3,
                bus.imm[4:1], bus.imm[11], bus.opcode};
      OP_LUI, OP_AUIPC:
        word = {bus.imm[31:12], bus.rd, bus.opcode};
      OP_JAL:
        word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
      default: begin
`ifdef ILLEGAL_OPCODE_CHECK_EN
        illegal = 1'b1;
`endif
        word = {bus.func7, bus.rs2, bus.rs1, bus.func3, bus.rd, bus.opcode};
      end
    endcase
  end

  assign full   = (occ == DEPTH_L);
  assign empty  = (occ == '0);
  assign accept = bus.in_valid && !full;
  assign push   = accept && !illegal;
  assign pop    = !empty && bus.mem_ready;

  // Word buffer between field input and memory; full blocks input, so push-on-full never happens.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= word;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      occ <= occ + (PTR_W+1)'(1);
      else if (pop && !push) occ <= occ - (PTR_W+1)'(1);
    end
  end

  // A start in the same cycle as a retirement wins over that retirement's increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= BASE_L;
      count_q <= '0;
    end else if (start) begin
      addr_q  <= BASE_L;
      count_q <= '0;
    end else if (pop) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (count_q != COUNT_MAX) count_q <= count_q + (ADDR_W+1)'(1);
    end
  end

`ifdef ILLEGAL_OPCODE_CHECK_EN
  logic       err_q;
  logic [7:0] err_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_q <= accept && illegal;
      if (accept && illegal && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err       = err_q;
  assign err_count = err_count_q;
`else
  assign err       = 1'b0;
  assign err_count = '0;
`endif

  assign bus.in_ready  = !full;
  assign bus.mem_we    = !empty;
  assign bus.mem_wdata = fifo_mem[rd_ptr];
  assign bus.mem_addr  = addr_q;
  assign count         = count_q;
  assign busy          = !empty;
endmodule

// File: tb/tb_instruction_assembler.sv
// Scoreboard bench for instruction_assembler: one instance at ADDR_W=8, one at ADDR_W=2 for wrap/saturation.
module tb_instruction_assembler;
  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] word;
  } tuple_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic valid_a = 1'b0, valid_b = 1'b0;
  logic ready_a = 1'b0, ready_b = 1'b0;
  logic [6:0]  f_op = '0;
  logic [4:0]  f_rd = '0, f_rs1 = '0, f_rs2 = '0;
  logic [2:0]  f_f3 = '0;
  logic [6:0]  f_f7 = '0;
  logic [31:0] f_imm = '0;

  logic [8:0] count_a;
  logic [2:0] count_b;
  logic       busy_a, busy_b, err_a, err_b;
  logic [7:0] err_count_a, err_count_b;

  int total = 0;
  int bad = 0;
  logic [31:0] sb_a[$];
  logic [31:0] sb_b[$];
  logic [7:0]  exp_addr_a = '0;
  logic [1:0]  exp_addr_b = '0;
  tuple_t tv[7];

  instruction_assembler_if #(.ADDR_W(8)) ifa ();
  instruction_assembler_if #(.ADDR_W(2)) ifb ();

  assign ifa.in_valid = valid_a;
  assign ifa.mem_ready = ready_a;
  assign ifa.opcode = f_op;
  assign ifa.rd = f_rd;
  assign ifa.func3 = f_f3;
  assign ifa.rs1 = f_rs1;
  assign ifa.rs2 = f_rs2;
  assign ifa.func7 = f_f7;
  assign ifa.imm = f_imm;
  assign ifb.in_valid = valid_b;
  assign ifb.mem_ready = ready_b;
  assign ifb.opcode = f_op;
  assign ifb.rd = f_rd;
  assign ifb.func3 = f_f3;
  assign ifb.rs1 = f_rs1;
  assign ifb.rs2 = f_rs2;
  assign ifb.func7 = f_f7;
  assign ifb.imm = f_imm;

  instruction_assembler #(.ADDR_W(8), .BASE_ADDR(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .bus(ifa.slave),
    .count(count_a), .busy(busy_a), .err(err_a), .err_count(err_count_a)
  );

  instruction_assembler #(.ADDR_W(2), .BASE_ADDR(0), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .bus(ifb.slave),
    .count(count_b), .busy(busy_b), .err(err_b), .err_count(err_count_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Offer one tuple, wait for the handshake and record the expected word if it should be written.
  task automatic applyStimulus(input bit sel, input tuple_t t, input bit exp_push);
    bit accepted = 1'b0;
    f_op = t.op; f_rd = t.rd; f_f3 = t.f3; f_rs1 = t.rs1;
    f_rs2 = t.rs2; f_f7 = t.f7; f_imm = t.imm;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      if (sel ? ifb.in_ready : ifa.in_ready) begin
        accepted = 1'b1;
        if (exp_push) begin
          if (sel) sb_b.push_back(t.word); else sb_a.push_back(t.word);
        end
      end
      @(posedge clk); #1;
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 0, 1);
    if (!exp_push && !sel) checkOutput("err_pulse", err_a, 1);
  endtask

  task automatic waitDrain(input bit sel);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = sel ? !busy_b : !busy_a;
    end
    if (!done) checkOutput("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    logic [31:0] w;
    if (reset_n) begin
      if (ifa.mem_we && ifa.mem_ready) begin
        if (sb_a.size() == 0) checkOutput("a_spurious_write", 1, 0);
        else begin
          w = sb_a.pop_front();
          checkOutput("a_wdata", ifa.mem_wdata, w);
          checkOutput("a_addr", ifa.mem_addr, exp_addr_a);
        end
        exp_addr_a = exp_addr_a + 8'd1;
      end
      if (start_a) exp_addr_a = '0;
    end
  end

  always @(negedge clk) begin
    logic [31:0] w;
    if (reset_n) begin
      if (ifb.mem_we && ifb.mem_ready) begin
        if (sb_b.size() == 0) checkOutput("b_spurious_write", 1, 0);
        else begin
          w = sb_b.pop_front();
          checkOutput("b_wdata", ifb.mem_wdata, w);
          checkOutput("b_addr", ifb.mem_addr, exp_addr_b);
        end
        exp_addr_b = exp_addr_b + 2'd1;
      end
      if (start_b) exp_addr_b = '0;
    end
  end

  initial begin
    tv[0] = '{7'h33, 5'd3,  3'd0, 5'd1, 5'd2, 7'h00, 32'd0,          32'h002081B3};
    tv[1] = '{7'h13, 5'd1,  3'd0, 5'd0, 5'd0, 7'h00, 32'd5,          32'h00500093};
    tv[2] = '{7'h23, 5'd31, 3'd2, 5'd1, 5'd2, 7'h7F, 32'd8,          32'h0020A423};
    tv[3] = '{7'h63, 5'd31, 3'd0, 5'd1, 5'd2, 7'h7F, 32'd16,         32'h00208863};
    tv[4] = '{7'h6F, 5'd1,  3'd0, 5'd0, 5'd0, 7'h00, 32'd2048,       32'h001000EF};
    tv[5] = '{7'h37, 5'd5,  3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000,   32'h123452B7};
    tv[6] = '{7'h7F, 5'd3,  3'd0, 5'd1, 5'd2, 7'h00, 32'd0,          32'h002081FF};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_we", ifa.mem_we, 0);
    checkOutput("rst_wdata", ifa.mem_wdata, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", ifa.in_ready, 1);
    checkOutput("rst_addr", ifa.mem_addr, 0);
    checkOutput("rst_count", count_a, 0);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_err", err_a, 0);
    checkOutput("rst_err_count", err_count_a, 0);

    ready_a = 1'b1;
    applyStimulus(0, tv[0], 1);
    checkOutput("latency_we", ifa.mem_we, 1);
    checkOutput("latency_wdata", ifa.mem_wdata, tv[0].word);
    waitDrain(0);
    checkOutput("add_count", count_a, 1);

    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    checkOutput("start_addr", ifa.mem_addr, 0);
    checkOutput("start_count", count_a, 0);

    for (int i = 1; i <= 5; i++) applyStimulus(0, tv[i], 1);
    waitDrain(0);
    checkOutput("burst_count", count_a, 5);
    checkOutput("burst_addr", ifa.mem_addr, 5);

    ready_a = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(0, tv[i], 1);
    checkOutput("bp_in_ready", ifa.in_ready, 0);
    checkOutput("bp_busy", busy_a, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_hold_we", ifa.mem_we, 1);
    checkOutput("bp_hold_addr", ifa.mem_addr, 5);
    checkOutput("bp_hold_wdata", ifa.mem_wdata, tv[0].word);
    checkOutput("bp_hold_in_ready", ifa.in_ready, 0);
    ready_a = 1'b1;
    applyStimulus(0, tv[4], 1);
    applyStimulus(0, tv[5], 1);
    waitDrain(0);
    checkOutput("bp_count", count_a, 11);

`ifdef ILLEGAL_OPCODE_CHECK_EN
    applyStimulus(0, tv[6], 0);
    @(posedge clk); #1;
    checkOutput("err_one_cycle", err_a, 0);
    checkOutput("err_count", err_count_a, 1);
    checkOutput("illegal_busy", busy_a, 0);
    checkOutput("illegal_count", count_a, 11);
`else
    applyStimulus(0, tv[6], 1);
    waitDrain(0);
    checkOutput("rfmt_count", count_a, 12);
    checkOutput("rfmt_err", err_a, 0);
    checkOutput("rfmt_err_count", err_count_a, 0);
`endif

    ready_a = 1'b0;
    for (int i = 1; i <= 3; i++) applyStimulus(0, tv[i], 1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_we", ifa.mem_we, 0);
    checkOutput("midrst_busy", busy_a, 0);
    sb_a.delete();
    exp_addr_a = '0;
    ready_a = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_addr", ifa.mem_addr, 0);
    checkOutput("midrst_count", count_a, 0);
    checkOutput("midrst_in_ready", ifa.in_ready, 1);
    checkOutput("midrst_we_after", ifa.mem_we, 0);

    ready_b = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1, tv[1], 1);
    waitDrain(1);
    checkOutput("b_count_sat", count_b, 4);
    checkOutput("b_addr_wrap", ifb.mem_addr, 1);
    ready_b = 1'b0;
    applyStimulus(1, tv[0], 1);
    applyStimulus(1, tv[2], 1);
    ready_b = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    checkOutput("b_start_count", count_b, 0);
    checkOutput("b_start_addr", ifb.mem_addr, 0);
    waitDrain(1);
    checkOutput("b_after_start_count", count_b, 1);

    checkOutput("sb_a_empty", sb_a.size(), 0);
    checkOutput("sb_b_empty", sb_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_assembler.md
# instruction_assembler

Packs decoded RV32I instruction fields (opcode, rd, func3, rs1, rs2, func7, immediate) back into 32-bit machine words and writes them sequentially into instruction memory. It sits between the test/boot program generator and the instruction memory write port, and is the inverse of the instruction field parser. A FIFO decouples field input from memory backpressure.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after reset or `start`
- FIFO_DEPTH, 4, encoded-word buffer entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  restart write sequence at BASE_ADDR
- in_valid  in  1  field tuple valid
- in_ready  out  1  block can accept a tuple
- opcode  in  7  instruction opcode
- rd  in  5  destination register
- func3  in  3  function-3 field
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- func7  in  7  function-7 field
- imm  in  32  sign-extended immediate (byte offset for B/J; upper-aligned for U)
- mem_we  out  1  memory write request
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts write this cycle
- count  out  ADDR_W+1  words written since reset/start, saturating
- busy  out  1  FIFO non-empty
- err  out  1  one-cycle pulse on dropped illegal opcode
- err_count  out  8  dropped tuples, saturating at 255

## Operation
- Accept: `in_valid && in_ready`; `in_ready = !full`. Word is encoded combinationally and pushed into the FIFO on that edge.
- Encoding by opcode:
  - R 0110011: {func7,rs2,rs1,func3,rd,opcode}
  - I 0010011/0000011/1100111/1110011: {imm[11:0],rs1,func3,rd,opcode}
  - S 0100011: {imm[11:5],rs2,rs1,func3,imm[4:0],opcode}
  - B 1100011: {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],opcode}
  - U 0110111/0010111: {imm[31:12],rd,opcode}
  - J 1101111: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
  - Other: see Configuration.
- Drain: `mem_we = !empty`; `mem_wdata` = FIFO head; the word retires on `mem_we && mem_ready`. `mem_addr` then increments, wrapping from 2^ADDR_W−1 to 0. `count` increments and saturates at 2^ADDR_W.
- A push and a pop in the same cycle are both performed, occupancy unchanged. When full, a pop and a push in the same cycle are allowed only if `in_ready` was already high, which it is not, so no push occurs when full.
- `start`: on the next edge `mem_addr`←BASE_ADDR and `count`←0. FIFO contents are kept. A retirement in the same cycle writes at the old address, and `start` overrides that cycle's increment.
- Reset (any time, including mid-drain): FIFO emptied, `mem_we`=0, `mem_addr`=BASE_ADDR, `count`=0, `busy`=0, `err`=0, `err_count`=0, `in_ready`=1 after release. `mem_wdata` reset value is 0.

## Timing
- Latency: tuple accepted at edge N → `mem_we`=1 with that word in cycle N+1 if FIFO was empty.
- Throughput: 1 word/cycle with `mem_ready` held high.
- `mem_we`/`mem_addr`/`mem_wdata` must stay stable while `mem_ready`=0.
- `in_ready` is registered-state derived. It has no combinational path from `mem_ready`.
- `err` is high for exactly the cycle after the dropping edge.

## Configuration
- `ILLEGAL_OPCODE_CHECK_EN` defined: a tuple with an unlisted opcode is accepted (handshake completes), not pushed, `err` pulses, and `err_count` increments (saturating at 255).
- Not defined: unlisted opcodes are encoded in R format and written normally. `err` and `err_count` are tied to 0.

## Test plan
- add x3,x1,x2 (opcode 0x33, rd 3, rs1 1, rs2 2, f3 0, f7 0) → `mem_wdata`=0x002081B3 at addr 0, one cycle after accept.
- Burst of addi x1,x0,5 / sw x2,8(x1) / beq x1,x2,+16 / jal x1,+2048 / lui x5,0x12345000, with `mem_ready`=1 → 0x00500093, 0x0020A423, 0x00208863, 0x001000EF, 0x123452B7 at addrs 0..4, `count`=5.
- Hold `mem_ready`=0, offer 6 tuples → `in_ready` drops after 4 accepts. Outputs remain stable. After `mem_ready`=1, all 6 words are written in order.
- ADDR_W=2: write 5 words → addresses 0,1,2,3,0 and `count`=4 (saturated). Then pulse `start` in the same cycle as a retirement → that word uses the old address, and the next word uses addr 0 with `count`=1.
- Macro on: opcode 0x7F → no write, `err` pulse, `err_count`=1. Macro off: the same tuple is written as an R-format word.
- Assert `reset_n`=0 with 3 words queued → `mem_we` drops immediately. After release, `busy`=0, `mem_addr`=0, `count`=0.
